// File: rtl/row_buf_ctrl.sv
// row_buf_ctrl: ping-pong row buffer controller between uart_bus and a
// two-bank line RAM. RX bytes fill the free bank, full banks are handed to
// the display reader, and every freed bank returns one ACK byte over UART TX.
// Build option: define ROW_CKSUM_EN to follow each ACK with the mod-256 sum
// of the freed row's bytes.
//
// bank state | meaning
// B_FREE     | bank empty, may be claimed by the write side
// B_FILLING  | write side is storing bytes of a row into it
// B_FULL     | complete row waiting for the display
// B_READING  | display owns it until show_row_done
//
// tx state   | meaning
// T_IDLE     | waiting for a pending ACK and tx_ready
// T_ACK      | ACK strobe on tx_data_valid
// T_WLO      | waiting for uart_bus to drop tx_ready
// T_WHI      | waiting for tx_ready to return
// T_SUM      | checksum strobe (ROW_CKSUM_EN only)
// T_SLO      | checksum byte: waiting for tx_ready low
// T_SHI      | checksum byte: waiting for tx_ready high
module row_buf_ctrl #(
    parameter int unsigned ROW_LEN  = 480,
    parameter int unsigned ROWS     = 320,
    parameter int unsigned ADDR_W   = 9,
    parameter logic [7:0]  ACK_BYTE = 8'h41
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_data_valid,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic              ram_wbank,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic              rd_valid,
    output logic              rd_bank,
    input  logic              show_row_done,
    input  logic              tx_ready,
    output logic              tx_data_valid,
    output logic [7:0]        tx_data,
    output logic [8:0]        row_idx,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(ROW_LEN - 1);
    localparam logic [8:0]        ROW_LAST = 9'(ROWS - 1);

    typedef enum logic [1:0] {
        B_FREE    = 2'd0,
        B_FILLING = 2'd1,
        B_FULL    = 2'd2,
        B_READING = 2'd3
    } bank_t;

    typedef enum logic [2:0] {
        T_IDLE = 3'd0,
        T_ACK  = 3'd1,
        T_WLO  = 3'd2,
        T_WHI  = 3'd3
`ifdef ROW_CKSUM_EN
        ,
        T_SUM  = 3'd4,
        T_SLO  = 3'd5,
        T_SHI  = 3'd6
`endif
    } tx_st_t;

    bank_t             bank_st   [2];
    bank_t             bank_st_n [2];
    logic              wr_have, wr_have_n;
    logic              wr_bank, wr_bank_n;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic              rd_valid_n, rd_bank_n;
    logic              eff_have, eff_bank, other_bank;
    logic              byte_ok, row_last, free_evt;
    logic [1:0]        ack_pend;
    logic              ack_inc, ack_dec;
    tx_st_t            tx_st, tx_st_n;

    // Effective write bank: when stalled, a bank that has gone FREE is usable at once.
    always_comb begin
        eff_have = wr_have;
        eff_bank = wr_bank;
        if (!wr_have) begin
            if (bank_st[0] == B_FREE) begin
                eff_have = 1'b1;
                eff_bank = 1'b0;
            end else if (bank_st[1] == B_FREE) begin
                eff_have = 1'b1;
                eff_bank = 1'b1;
            end
        end
        other_bank = ~eff_bank;
    end

    assign byte_ok  = rx_data_valid & eff_have;
    assign row_last = byte_ok && (wr_ptr == LAST_PTR);
    assign free_evt = show_row_done & rd_valid;
    assign ack_inc  = free_evt;
    assign ack_dec  = (tx_st == T_ACK);

    // Bank bookkeeping: write fill/complete, display claim, display release.
    always_comb begin
        bank_st_n[0] = bank_st[0];
        bank_st_n[1] = bank_st[1];
        wr_have_n    = eff_have;
        wr_bank_n    = eff_bank;
        wr_ptr_n     = wr_ptr;
        rd_valid_n   = rd_valid;
        rd_bank_n    = rd_bank;

        if (byte_ok) begin
            if (row_last) begin
                bank_st_n[eff_bank] = B_FULL;
                wr_ptr_n            = '0;
                // A bank freed in this same cycle counts as free for the hand-over.
                if ((bank_st[other_bank] == B_FREE) || (free_evt && (rd_bank == other_bank))) begin
                    wr_bank_n = other_bank;
                end else begin
                    wr_have_n = 1'b0;
                end
            end else begin
                bank_st_n[eff_bank] = B_FILLING;
                wr_ptr_n            = wr_ptr + ADDR_W'(1);
            end
        end

        if (free_evt) begin
            bank_st_n[rd_bank] = B_FREE;
            rd_valid_n         = 1'b0;
        end else if (!rd_valid) begin
            // Only one bank can be FULL while the reader is idle, so the
            // bank-0 preference also yields strict oldest-first order.
            if (bank_st[0] == B_FULL) begin
                rd_valid_n   = 1'b1;
                rd_bank_n    = 1'b0;
                bank_st_n[0] = B_READING;
            end else if (bank_st[1] == B_FULL) begin
                rd_valid_n   = 1'b1;
                rd_bank_n    = 1'b1;
                bank_st_n[1] = B_READING;
            end
        end
    end

    // Bank, write-pointer and reader state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0] <= B_FREE;
            bank_st[1] <= B_FREE;
            wr_have    <= 1'b1;
            wr_bank    <= 1'b0;
            wr_ptr     <= '0;
            rd_valid   <= 1'b0;
            rd_bank    <= 1'b0;
        end else begin
            bank_st[0] <= bank_st_n[0];
            bank_st[1] <= bank_st_n[1];
            wr_have    <= wr_have_n;
            wr_bank    <= wr_bank_n;
            wr_ptr     <= wr_ptr_n;
            rd_valid   <= rd_valid_n;
            rd_bank    <= rd_bank_n;
        end
    end

    // RAM write port, one cycle behind the accepted RX byte; sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we    <= 1'b0;
            ram_wbank <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            overrun   <= 1'b0;
        end else begin
            ram_we <= byte_ok;
            if (byte_ok) begin
                ram_wbank <= eff_bank;
                ram_waddr <= wr_ptr;
                ram_wdata <= rx_data;
            end
            if (rx_data_valid && !eff_have) begin
                overrun <= 1'b1;
            end
        end
    end

    // Row counter within the frame and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= free_evt && (row_idx == ROW_LAST);
            if (free_evt) begin
                row_idx <= (row_idx == ROW_LAST) ? 9'd0 : row_idx + 9'd1;
            end
        end
    end

    // Pending ACK credit: saturates at two, simultaneous inc/dec cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_pend <= 2'd2;
        end else begin
            case ({ack_inc, ack_dec})
                2'b10:   if (ack_pend != 2'd2) ack_pend <= ack_pend + 2'd1;
                2'b01:   ack_pend <= ack_pend - 2'd1;
                default: ack_pend <= ack_pend;
            endcase
        end
    end

`ifdef ROW_CKSUM_EN
    logic [7:0] row_sum, row_sum_n;
    logic [7:0] bank_sum [2];
    logic [7:0] sum_q0, sum_q1, sum_out;

    assign row_sum_n = ((wr_ptr == '0) ? 8'd0 : row_sum) + rx_data;

    // Running row sum, latched per bank when the row completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sum     <= '0;
            bank_sum[0] <= '0;
            bank_sum[1] <= '0;
        end else if (byte_ok) begin
            row_sum <= row_sum_n;
            if (row_last) begin
                bank_sum[eff_bank] <= row_sum_n;
            end
        end
    end

    // Two-deep checksum queue kept in step with ack_pend; the reset credits carry zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q0  <= '0;
            sum_q1  <= '0;
            sum_out <= '0;
        end else begin
            if (ack_dec) begin
                sum_out <= sum_q0;
            end
            case ({ack_inc, ack_dec})
                2'b11: begin
                    if (ack_pend == 2'd1) begin
                        sum_q0 <= bank_sum[rd_bank];
                    end else begin
                        sum_q0 <= sum_q1;
                        sum_q1 <= bank_sum[rd_bank];
                    end
                end
                2'b01: sum_q0 <= sum_q1;
                2'b10: begin
                    if (ack_pend == 2'd0) begin
                        sum_q0 <= bank_sum[rd_bank];
                    end else if (ack_pend == 2'd1) begin
                        sum_q1 <= bank_sum[rd_bank];
                    end
                end
                default: sum_q0 <= sum_q0;
            endcase
        end
    end
`endif

    // TX FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st <= T_IDLE;
        end else begin
            tx_st <= tx_st_n;
        end
    end

    // TX FSM next state and strobe.
    always_comb begin
        tx_st_n       = tx_st;
        tx_data_valid = 1'b0;
        case (tx_st)
            T_IDLE: if ((ack_pend != 2'd0) && tx_ready) tx_st_n = T_ACK;
            T_ACK: begin
                tx_data_valid = 1'b1;
                tx_st_n       = T_WLO;
            end
            T_WLO: if (!tx_ready) tx_st_n = T_WHI;
`ifdef ROW_CKSUM_EN
            T_WHI: if (tx_ready) tx_st_n = T_SUM;
            T_SUM: begin
                tx_data_valid = 1'b1;
                tx_st_n       = T_SLO;
            end
            T_SLO: if (!tx_ready) tx_st_n = T_SHI;
            T_SHI: if (tx_ready) tx_st_n = T_IDLE;
`else
            T_WHI: if (tx_ready) tx_st_n = T_IDLE;
`endif
            default: tx_st_n = T_IDLE;
        endcase
    end

    // TX byte is loaded on entry to a strobe state and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= '0;
        end else if (tx_st_n == T_ACK) begin
            tx_data <= ACK_BYTE;
`ifdef ROW_CKSUM_EN
        end else if (tx_st_n == T_SUM) begin
            tx_data <= sum_out;
`endif
        end
    end

endmodule

// File: tb/tb_row_buf_ctrl.sv
// Self-checking bench for row_buf_ctrl: scenario table plus hand-written
// sequences for write addressing, overrun, release timing and frame wrap.
module tb_row_buf_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_data_valid, show_row_done, tx_ready;
    logic [7:0] rx_data;
    logic       ram_we, ram_wbank, rd_valid, rd_bank, tx_data_valid, frame_done, overrun;
    logic [8:0] ram_waddr, row_idx;
    logic [7:0] ram_wdata, tx_data;

    logic       f_rx_valid, f_done, f_tx_ready;
    logic [7:0] f_rx_data;
    logic       f_ram_we, f_ram_wbank, f_rd_valid, f_rd_bank, f_tx_valid, f_frame_done, f_overrun;
    logic [2:0] f_ram_waddr;
    logic [8:0] f_row_idx;
    logic [7:0] f_ram_wdata, f_tx_data;

    always #5 clk = ~clk;

    row_buf_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data_valid(rx_data_valid), .rx_data(rx_data),
        .ram_we(ram_we), .ram_wbank(ram_wbank), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .rd_valid(rd_valid), .rd_bank(rd_bank), .show_row_done(show_row_done),
        .tx_ready(tx_ready), .tx_data_valid(tx_data_valid), .tx_data(tx_data),
        .row_idx(row_idx), .frame_done(frame_done), .overrun(overrun)
    );

    // Short rows so a full 320-row frame fits the cycle budget.
    row_buf_ctrl #(.ROW_LEN(8), .ROWS(320), .ADDR_W(3)) u_frame (
        .clk(clk), .rst_n(rst_n),
        .rx_data_valid(f_rx_valid), .rx_data(f_rx_data),
        .ram_we(f_ram_we), .ram_wbank(f_ram_wbank), .ram_waddr(f_ram_waddr), .ram_wdata(f_ram_wdata),
        .rd_valid(f_rd_valid), .rd_bank(f_rd_bank), .show_row_done(f_done),
        .tx_ready(f_tx_ready), .tx_data_valid(f_tx_valid), .tx_data(f_tx_data),
        .row_idx(f_row_idx), .frame_done(f_frame_done), .overrun(f_overrun)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // UART TX model: accepts a strobe, drops tx_ready for three cycles.
    int         ack_cnt = 0;
    logic [7:0] last_tx = 8'h00;
    logic [7:0] prev_tx = 8'h00;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && tx_data_valid) begin
                prev_tx = last_tx;
                last_tx = tx_data;
                if (tx_data == 8'h41) ack_cnt++;
                tx_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        end
    end

    // RAM write monitor for a plain stream of bytes idx mod 256.
    bit mon_en = 1'b0;
    int mon_idx = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && ram_we) begin
                check("wr_bank", ram_wbank, (mon_idx / 480) % 2);
                check("wr_addr", ram_waddr, mon_idx % 480);
                check("wr_data", ram_wdata, mon_idx % 256);
                mon_idx++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
        show_row_done = 1'b0;
        f_rx_valid    = 1'b0;
        f_rx_data     = 8'h00;
        f_done        = 1'b0;
        rst_n         = 1'b0;
        repeat (3) tick();
        ack_cnt = 0;
        last_tx = 8'h00;
        prev_tx = 8'h00;
        rst_n   = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx_data_valid = 1'b1;
        rx_data       = d;
        tick();
        rx_data_valid = 1'b0;
    endtask

    task automatic stream_seq(input int start, input int n);
        for (int i = 0; i < n; i++) send_byte(8'((start + i) % 256));
    endtask

    task automatic pulse_done();
        show_row_done = 1'b1;
        tick();
        show_row_done = 1'b0;
    endtask

    task automatic wait_rd(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rd_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    typedef struct {
        int nbytes;
        int ndone;
        bit force_done;
        bit exp_rdv;
        bit exp_rdb;
        bit exp_ov;
        int exp_row;
        int exp_acks;
    } vec_t;

    vec_t vt [9];
    bit   ok;
    int   fd_cnt, fd_row, fr_tmo;

    initial begin
        //        bytes ndone force rdv rdb ov row acks
        vt[0] = '{0,    0,    0,    0,  0,  0, 0,  2};
        vt[1] = '{479,  0,    0,    0,  0,  0, 0,  2};
        vt[2] = '{480,  0,    0,    1,  0,  0, 0,  2};
        vt[3] = '{480,  1,    0,    0,  0,  0, 1,  3};
        vt[4] = '{960,  1,    0,    1,  1,  0, 1,  3};
        vt[5] = '{961,  0,    0,    1,  0,  1, 0,  2};
        vt[6] = '{960,  2,    0,    0,  1,  0, 2,  4};
        vt[7] = '{0,    1,    1,    0,  0,  0, 0,  2};
        vt[8] = '{1440, 2,    0,    0,  1,  1, 2,  4};

        // Reset values, then the two reset-time ACKs with tx_ready handshake.
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
        show_row_done = 1'b0;
        f_rx_valid    = 1'b0;
        f_rx_data     = 8'h00;
        f_done        = 1'b0;
        f_tx_ready    = 1'b1;
        rst_n         = 1'b0;
        repeat (3) tick();
        check("rst_ram_we", ram_we, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_tx_valid", tx_data_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        ack_cnt = 0;
        rst_n   = 1'b1;
        repeat (60) tick();
        check("idle_acks", ack_cnt, 2);
        check("idle_tx_data", tx_data, 8'h41);
        check("idle_rd_valid", rd_valid, 0);
        check("idle_ram_we", ram_we, 0);
        check("idle_overrun", overrun, 0);

        // First row: addresses 0..479 in bank 0, then handed to the reader.
        do_reset();
        mon_idx = 0;
        mon_en  = 1'b1;
        stream_seq(0, 480);
        tick();
        tick();
        check("row0_writes", mon_idx, 480);
        check("row0_rd_valid", rd_valid, 1);
        check("row0_rd_bank", rd_bank, 0);

        // Second row into bank 1, then byte 961 has nowhere to go.
        stream_seq(480, 480);
        send_byte(8'hA5);
        check("ovr_ram_we", ram_we, 0);
        check("ovr_overrun", overrun, 1);
        tick();
        check("ovr_writes", mon_idx, 960);
        check("ovr_rd_valid", rd_valid, 1);
        check("ovr_rd_bank", rd_bank, 0);

        // Release bank 0: reader drops for one cycle then takes bank 1.
        show_row_done = 1'b1;
        tick();
        show_row_done = 1'b0;
        check("rel_rd_valid_n1", rd_valid, 0);
        tick();
        check("rel_rd_valid_n2", rd_valid, 1);
        check("rel_rd_bank_n2", rd_bank, 1);
        check("rel_row_idx", row_idx, 1);
        send_byte(8'(960 % 256));
        tick();
        tick();
        check("rel_writes", mon_idx, 961);
        mon_en = 1'b0;
        repeat (40) tick();
        check("rel_acks", ack_cnt, 3);
        check("rel_last_tx", last_tx, 8'h41);
        check("rel_overrun_sticky", overrun, 1);

        // Scenario table.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            stream_seq(0, vt[i].nbytes);
            for (int d = 0; d < vt[i].ndone; d++) begin
                if (!vt[i].force_done) begin
                    wait_rd(ok);
                    check($sformatf("vec%0d_wait", i), ok, 1);
                end
                pulse_done();
                repeat (3) tick();
            end
            repeat (40) tick();
            check($sformatf("vec%0d_rd_valid", i), rd_valid, vt[i].exp_rdv);
            check($sformatf("vec%0d_rd_bank", i), rd_bank, vt[i].exp_rdb);
            check($sformatf("vec%0d_overrun", i), overrun, vt[i].exp_ov);
            check($sformatf("vec%0d_row_idx", i), row_idx, vt[i].exp_row);
            check($sformatf("vec%0d_acks", i), ack_cnt, vt[i].exp_acks);
        end

        // Full frame of 320 short rows on the second instance.
        do_reset();
        fd_cnt = 0;
        fd_row = -1;
        fr_tmo = 0;
        for (int r = 0; r < 320; r++) begin
            for (int b = 0; b < 8; b++) begin
                f_rx_valid = 1'b1;
                f_rx_data  = 8'(b);
                tick();
            end
            f_rx_valid = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                if (f_rd_valid) ok = 1'b1;
                else tick();
            end
            if (!ok) fr_tmo++;
            if (r == 319) begin
                check("frame_row_idx_before", f_row_idx, 319);
                check("frame_no_early_pulse", fd_cnt, 0);
            end
            f_done = 1'b1;
            tick();
            f_done = 1'b0;
            if (f_frame_done) begin
                fd_cnt++;
                fd_row = r;
            end
            tick();
            check("frame_pulse_width", f_frame_done, 0);
        end
        check("frame_timeouts", fr_tmo, 0);
        check("frame_pulses", fd_cnt, 1);
        check("frame_pulse_row", fd_row, 319);
        check("frame_row_idx_wrap", f_row_idx, 0);

`ifdef ROW_CKSUM_EN
        do_reset();
        repeat (60) tick();
        for (int i = 0; i < 480; i++) send_byte(8'h01);
        wait_rd(ok);
        check("ck_wait", ok, 1);
        pulse_done();
        repeat (60) tick();
        check("ck_ack_byte", prev_tx, 8'h41);
        check("ck_sum_byte", last_tx, 8'hE0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
